axi4_write_txn_collector: RTL and testbench

AXI4_WRITE_TXN_COLLECTOR -- requirements
Module: axi4_write_txn_collector

---
 rtl/axi4_write_txn_collector_if.sv | 22 ++
 rtl/axi4_write_txn_collector.sv | 161 ++++++++++++++++
 tb/tb_axi4_write_txn_collector.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_write_txn_collector_if.sv
// AXI4 write-address and write-data channel bundle.
// The monitor modport is a passive, read-only tap.
interface axi4_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4
);
    logic                          awvalid;
    logic                          awready;
    logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
    logic [AXI4_ID_WIDTH-1:0]      awid;
    logic [7:0]                    awlen;
    logic                          wvalid;
    logic                          wready;
    logic [AXI4_DATA_WIDTH-1:0]    wdata;
    logic                          wlast;

    modport monitor (
        input awvalid, awready, awaddr, awid, awlen,
        input wvalid, wready, wdata, wlast
    );
endinterface

// File: rtl/axi4_write_txn_collector.sv
// Passive AXI4 write monitor: pairs each AW with its W burst
// (in order) and emits one summary record per completed write.
module axi4_write_txn_collector #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    axi4_if.monitor                       monitor,
    output logic                          txn_valid,
    input  logic                          txn_ready,
    output logic [AXI4_ADDRESS_WIDTH-1:0] txn_addr,
    output logic [AXI4_ID_WIDTH-1:0]      txn_id,
    output logic [7:0]                    txn_len,
    output logic [8:0]                    txn_beats,
    output logic [AXI4_DATA_WIDTH-1:0]    txn_data0,
    output logic                          txn_len_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   addr_count,
    output logic [$clog2(FIFO_DEPTH):0]   burst_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          wl_hs;
    logic [8:0]                    cnt;
    logic [8:0]                    cnt_inc;
    logic [AXI4_DATA_WIDTH-1:0]    d0;
    logic [AXI4_DATA_WIDTH-1:0]    first_data;

    logic [AXI4_ADDRESS_WIDTH-1:0] a_addr_mem [FIFO_DEPTH];
    logic [AXI4_ID_WIDTH-1:0]      a_id_mem   [FIFO_DEPTH];
    logic [7:0]                    a_len_mem  [FIFO_DEPTH];
    logic [8:0]                    b_beat_mem [FIFO_DEPTH];
    logic [AXI4_DATA_WIDTH-1:0]    b_data_mem [FIFO_DEPTH];

    logic [PW-1:0] a_wp, a_rp, b_wp, b_rp;
    logic          a_full, b_full;
    logic          pop;
    logic          a_push, b_push;
    logic          a_drop, b_drop;

    assign aw_hs = monitor.awvalid && monitor.awready;
    assign w_hs  = monitor.wvalid && monitor.wready;
    assign wl_hs = w_hs && monitor.wlast;

    assign cnt_inc    = (cnt == 9'd511) ? cnt : cnt + 9'd1;
    assign first_data = (cnt == 9'd0) ? monitor.wdata : d0;

    assign a_full = (addr_count == CW'(FIFO_DEPTH));
    assign b_full = (burst_count == CW'(FIFO_DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop    = (addr_count != '0) && (burst_count != '0) &&
                    (!txn_valid || txn_ready);
    assign a_push = aw_hs && (!a_full || pop);
    assign b_push = wl_hs && (!b_full || pop);
    assign a_drop = aw_hs && a_full && !pop;
    assign b_drop = wl_hs && b_full && !pop;

    // Beat counter and first-beat data capture for the burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            d0  <= '0;
        end else if (w_hs) begin
            if (monitor.wlast) begin
                cnt <= '0;
            end else begin
                if (cnt == 9'd0)
                    d0 <= monitor.wdata;
                cnt <= cnt_inc;
            end
        end
    end

    // FIFO storage; contents are don't-care outside the valid window.
    always_ff @(posedge clk) begin
        if (!rst && a_push) begin
            a_addr_mem[a_wp] <= monitor.awaddr;
            a_id_mem[a_wp]   <= monitor.awid;
            a_len_mem[a_wp]  <= monitor.awlen;
        end
        if (!rst && b_push) begin
            b_beat_mem[b_wp] <= cnt_inc;
            b_data_mem[b_wp] <= first_data;
        end
    end

    // Address FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_wp       <= '0;
            a_rp       <= '0;
            addr_count <= '0;
        end else begin
            if (a_push)
                a_wp <= a_wp + PW'(1);
            if (pop)
                a_rp <= a_rp + PW'(1);
            if (a_push && !pop)
                addr_count <= addr_count + CW'(1);
            else if (!a_push && pop)
                addr_count <= addr_count - CW'(1);
        end
    end

    // Burst FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_wp        <= '0;
            b_rp        <= '0;
            burst_count <= '0;
        end else begin
            if (b_push)
                b_wp <= b_wp + PW'(1);
            if (pop)
                b_rp <= b_rp + PW'(1);
            if (b_push && !pop)
                burst_count <= burst_count + CW'(1);
            else if (!b_push && pop)
                burst_count <= burst_count - CW'(1);
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (a_drop || b_drop)
            overflow <= 1'b1;
    end

    // Output record register; payload holds until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_valid   <= 1'b0;
            txn_addr    <= '0;
            txn_id      <= '0;
            txn_len     <= '0;
            txn_beats   <= '0;
            txn_data0   <= '0;
            txn_len_err <= 1'b0;
        end else if (pop) begin
            txn_valid   <= 1'b1;
            txn_addr    <= a_addr_mem[a_rp];
            txn_id      <= a_id_mem[a_rp];
            txn_len     <= a_len_mem[a_rp];
            txn_beats   <= b_beat_mem[b_rp];
            txn_data0   <= b_data_mem[b_rp];
            txn_len_err <= b_beat_mem[b_rp] !=
                           ({1'b0, a_len_mem[a_rp]} + 9'd1);
        end else if (txn_ready) begin
            txn_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_write_txn_collector.sv
// Randomized and directed bench for axi4_write_txn_collector,
// checked every cycle against a queue-based transaction model.
module tb_axi4_write_txn_collector;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          txn_valid;
    logic          txn_ready;
    logic [AW-1:0] txn_addr;
    logic [IW-1:0] txn_id;
    logic [7:0]    txn_len;
    logic [8:0]    txn_beats;
    logic [DW-1:0] txn_data0;
    logic          txn_len_err;
    logic          overflow;
    logic [2:0]    addr_count;
    logic [2:0]    burst_count;

    axi4_if #(
        .AXI4_ADDRESS_WIDTH(AW),
        .AXI4_DATA_WIDTH(DW),
        .AXI4_ID_WIDTH(IW)
    ) bus ();

    axi4_write_txn_collector #(
        .AXI4_ADDRESS_WIDTH(AW),
        .AXI4_DATA_WIDTH(DW),
        .AXI4_ID_WIDTH(IW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .monitor(bus),
        .txn_valid(txn_valid),
        .txn_ready(txn_ready),
        .txn_addr(txn_addr),
        .txn_id(txn_id),
        .txn_len(txn_len),
        .txn_beats(txn_beats),
        .txn_data0(txn_data0),
        .txn_len_err(txn_len_err),
        .overflow(overflow),
        .addr_count(addr_count),
        .burst_count(burst_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
    } a_t;

    typedef struct {
        int            beats;
        logic [DW-1:0] data;
    } b_t;

    a_t aq[$];
    b_t bq[$];

    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_id;
    logic [7:0]    m_len;
    int            m_beats;
    logic [DW-1:0] m_data;
    logic          m_err;
    logic          m_ovf;
    int            m_cnt;
    logic [DW-1:0] m_d0;

    int vectors = 0;
    int errors = 0;
    int dut_acc = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        aq.delete();
        bq.delete();
        m_valid = 1'b0;
        m_addr  = '0;
        m_id    = '0;
        m_len   = '0;
        m_beats = 0;
        m_data  = '0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        m_d0    = '0;
    endtask

    // One clock edge of the transaction-level model, using driven inputs.
    task automatic model_edge();
        bit pop;
        a_t a;
        b_t b;
        int nb;
        if (rst) begin
            model_clear();
            return;
        end
        pop = (aq.size() > 0) && (bq.size() > 0) && (!m_valid || txn_ready);
        if (pop) begin
            a = aq.pop_front();
            b = bq.pop_front();
            m_valid = 1'b1;
            m_addr  = a.addr;
            m_id    = a.id;
            m_len   = a.len;
            m_beats = b.beats;
            m_data  = b.data;
            m_err   = (b.beats != int'(a.len) + 1);
        end else if (m_valid && txn_ready) begin
            m_valid = 1'b0;
        end
        if (bus.awvalid && bus.awready) begin
            a.addr = bus.awaddr;
            a.id   = bus.awid;
            a.len  = bus.awlen;
            if (aq.size() < DEPTH) aq.push_back(a);
            else m_ovf = 1'b1;
        end
        if (bus.wvalid && bus.wready) begin
            nb = (m_cnt + 1 > 511) ? 511 : m_cnt + 1;
            if (bus.wlast) begin
                b.beats = nb;
                b.data  = (m_cnt == 0) ? bus.wdata : m_d0;
                if (bq.size() < DEPTH) bq.push_back(b);
                else m_ovf = 1'b1;
                m_cnt = 0;
            end else begin
                if (m_cnt == 0) m_d0 = bus.wdata;
                m_cnt = nb;
            end
        end
    endtask

    task automatic compare();
        chk("txn_valid", txn_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("addr_count", addr_count, aq.size());
        chk("burst_count", burst_count, bq.size());
        chk("txn_addr", txn_addr, m_addr);
        chk("txn_id", txn_id, m_id);
        chk("txn_len", txn_len, m_len);
        chk("txn_beats", txn_beats, m_beats);
        chk("txn_data0", txn_data0, m_data);
        chk("txn_len_err", txn_len_err, m_err);
    endtask

    task automatic cyc();
        if (txn_valid && txn_ready && !rst) dut_acc++;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic quiet();
        bus.awvalid = 1'b0;
        bus.awready = 1'b0;
        bus.wvalid  = 1'b0;
        bus.wready  = 1'b0;
        bus.wlast   = 1'b0;
    endtask

    task automatic send_aw(logic [AW-1:0] a, logic [IW-1:0] id,
                           logic [7:0] len);
        bus.awvalid = 1'b1;
        bus.awready = 1'b1;
        bus.awaddr  = a;
        bus.awid    = id;
        bus.awlen   = len;
        cyc();
        quiet();
    endtask

    task automatic send_w(logic [DW-1:0] d, logic last);
        bus.wvalid = 1'b1;
        bus.wready = 1'b1;
        bus.wdata  = d;
        bus.wlast  = last;
        cyc();
        quiet();
    endtask

    task automatic send_pair(logic [AW-1:0] a, logic [DW-1:0] d);
        bus.awvalid = 1'b1;
        bus.awready = 1'b1;
        bus.awaddr  = a;
        bus.awid    = a[3:0];
        bus.awlen   = 8'd0;
        bus.wvalid  = 1'b1;
        bus.wready  = 1'b1;
        bus.wdata   = d;
        bus.wlast   = 1'b1;
        cyc();
        quiet();
    endtask

    initial begin
        quiet();
        bus.awaddr = '0;
        bus.awid   = '0;
        bus.awlen  = '0;
        bus.wdata  = '0;
        model_clear();
        rst = 1'b1;
        txn_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        // single-beat write, AW first
        send_aw(32'h1000, 4'd2, 8'd0);
        send_w(32'hDEADBEEF, 1'b1);
        cyc();
        chk("t1_valid", txn_valid, 1);
        chk("t1_addr", txn_addr, 32'h1000);
        chk("t1_id", txn_id, 2);
        chk("t1_beats", txn_beats, 1);
        chk("t1_data", txn_data0, 32'hDEADBEEF);
        chk("t1_err", txn_len_err, 0);
        idle(2);

        // W burst before its AW
        send_w(32'h11, 1'b0);
        send_w(32'h22, 1'b0);
        send_w(32'h33, 1'b0);
        send_w(32'h44, 1'b1);
        chk("t2_bcnt", burst_count, 1);
        idle(4);
        chk("t2_bcnt_hold", burst_count, 1);
        send_aw(32'h2000, 4'd0, 8'd3);
        cyc();
        chk("t2_valid", txn_valid, 1);
        chk("t2_beats", txn_beats, 4);
        chk("t2_data", txn_data0, 32'h11);
        chk("t2_err", txn_len_err, 0);
        idle(2);

        // short burst flags a length error
        send_aw(32'h2100, 4'd1, 8'd3);
        send_w(32'hA1, 1'b0);
        send_w(32'hA2, 1'b1);
        cyc();
        chk("t3_beats", txn_beats, 2);
        chk("t3_len", txn_len, 3);
        chk("t3_err", txn_len_err, 1);
        idle(2);

        // overflow with consumer stalled
        txn_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            send_pair(32'h4000 + 32'(i), 32'h100 + 32'(i));
        chk("t4_ovf", overflow, 1);
        txn_ready = 1'b1;
        dut_acc = 0;
        idle(8);
        chk("t4_records", dut_acc, 5);
        chk("t4_ovf_sticky", overflow, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t4_ovf_clr", overflow, 0);

        // reset mid-burst discards the partial burst
        send_aw(32'h3F00, 4'd3, 8'd3);
        send_w(32'hB1, 1'b0);
        send_w(32'hB2, 1'b0);
        rst = 1'b1;
        cyc();
        chk("t5_rst_valid", txn_valid, 0);
        rst = 1'b0;
        send_aw(32'h3000, 4'd5, 8'd1);
        send_w(32'hC1, 1'b0);
        send_w(32'hC2, 1'b1);
        cyc();
        chk("t5_addr", txn_addr, 32'h3000);
        chk("t5_beats", txn_beats, 2);
        chk("t5_data", txn_data0, 32'hC1);
        chk("t5_err", txn_len_err, 0);
        idle(2);

        // back-to-back drain of three queued pairs
        txn_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_pair(32'h6000 + 32'(i), 32'h600 + 32'(i));
        idle(2);
        txn_ready = 1'b1;
        chk("t6_v0", txn_valid, 1);
        cyc();
        chk("t6_v1", txn_valid, 1);
        cyc();
        chk("t6_v2", txn_valid, 1);
        cyc();
        chk("t6_v3", txn_valid, 0);
        idle(1);

        // beat counter saturates at 511
        send_aw(32'h5000, 4'd7, 8'd255);
        bus.wvalid = 1'b1;
        bus.wready = 1'b1;
        bus.wlast  = 1'b0;
        for (int i = 0; i < 520; i++) begin
            bus.wdata = 32'(i) + 32'h7000;
            cyc();
        end
        bus.wlast = 1'b1;
        cyc();
        quiet();
        cyc();
        chk("t7_beats", txn_beats, 511);
        chk("t7_data", txn_data0, 32'h7000);
        chk("t7_err", txn_len_err, 1);
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 399) == 0);
            txn_ready   = ($urandom_range(0, 3) != 0);
            bus.awvalid = ($urandom_range(0, 2) == 0);
            bus.awready = ($urandom_range(0, 3) != 0);
            bus.awaddr  = $urandom();
            bus.awid    = 4'($urandom());
            bus.awlen   = 8'($urandom_range(0, 3));
            bus.wvalid  = ($urandom_range(0, 1) == 0);
            bus.wready  = ($urandom_range(0, 3) != 0);
            bus.wdata   = $urandom();
            bus.wlast   = ($urandom_range(0, 2) == 0);
            cyc();
        end
        rst = 1'b0;
        quiet();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
